// File: rtl/aes_sub_multicycle.sv
// aes_sub_multicycle - AES SubBytes over four selected bytes, time-multiplexed
// across SBOXES sbox instances (1, 2 or 4). One group of SBOXES bytes is
// substituted per RUN cycle; the result is presented for a single DONE cycle.
//
// Ports:
//   g_clk    in   1   clock, rising edge
//   g_reset  in   1   synchronous active-high reset
//   valid    in   1   instruction valid, held until ready
//   rs1      in  32   source 1 (bytes 0 and 2 used)
//   rs2      in  32   source 2 (bytes 1 and 3 used)
//   enc      in   1   1 = forward sbox, 0 = inverse sbox
//   rot      in   1   1 = rotate result left by one byte
//   ready    out  1   result valid pulse
//   rd       out 32   result, zero when ready is low
//
// Optional build macro: AES_SUB_MULTICYCLE_MASK_EN - when defined, sbox inputs
// and the inverse select are held at zero outside RUN.

module aes_sbox (
  input  logic [7:0] in_i,
  input  logic       inv_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = xtime(t);
    end
    gf_mul = p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    gf_inv = acc;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    affine_fwd = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                   ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    affine_inv = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] pre_s;
  logic [7:0] gi_s;

  // Forward: inverse then affine. Inverse: inverse-affine then inverse.
  always_comb begin
    pre_s = inv_i ? affine_inv(in_i) : in_i;
    gi_s  = gf_inv(pre_s);
    out_o = inv_i ? gi_s : affine_fwd(gi_s);
  end

endmodule

module aes_sub_multicycle #(
  parameter int SBOXES = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        rot,
  output logic        ready,
  output logic [31:0] rd
);

  localparam int N  = 4 / SBOXES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(SBOXES == 1 || SBOXES == 2 || SBOXES == 4)) begin : g_bad_sboxes
    $error("aes_sub_multicycle: SBOXES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lat_q [4];
  logic [7:0]    lat_d [4];
  logic [7:0]    res_q [4];
  logic [7:0]    res_d [4];
  logic          enc_q, enc_d;
  logic          rot_q, rot_d;

  logic [1:0]    idx_s    [SBOXES];
  logic [7:0]    sb_in_s  [SBOXES];
  logic [7:0]    sb_out_s [SBOXES];
  logic          sb_inv_s;

  // Only bytes 0/2 of rs1 and 1/3 of rs2 feed the datapath.
  logic unused_s;
  assign unused_s = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

  for (genvar j = 0; j < SBOXES; j++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sb_in_s[j]),
      .inv_i (sb_inv_s),
      .out_o (sb_out_s[j])
    );
  end

  // Sbox input selection: group cnt_q of the latched bytes.
  always_comb begin
    for (int j = 0; j < SBOXES; j++) begin
      idx_s[j] = 2'(32'(cnt_q) * SBOXES + j);
`ifdef AES_SUB_MULTICYCLE_MASK_EN
      sb_in_s[j] = (state_q == RUN) ? lat_q[idx_s[j]] : 8'h00;
`else
      sb_in_s[j] = lat_q[idx_s[j]];
`endif
    end
`ifdef AES_SUB_MULTICYCLE_MASK_EN
    sb_inv_s = (state_q == RUN) ? ~enc_q : 1'b0;
`else
    sb_inv_s = ~enc_q;
`endif
  end

  // Next-state logic: accept in IDLE, one group per RUN cycle, abort on valid drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    res_d   = res_q;
    enc_d   = enc_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          lat_d[0] = rs1[7:0];
          lat_d[1] = rs2[15:8];
          lat_d[2] = rs1[23:16];
          lat_d[3] = rs2[31:24];
          enc_d    = enc;
          rot_d    = rot;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (!valid) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          for (int j = 0; j < SBOXES; j++) begin
            res_d[idx_s[j]] = sb_out_s[j];
          end
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      enc_q   <= 1'b0;
      rot_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lat_q[i] <= 8'h00;
        res_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      rot_q   <= rot_d;
      lat_q   <= lat_d;
      res_q   <= res_d;
    end
  end

  // Outputs come from registered state only; rd is zero outside DONE.
  always_comb begin
    ready = (state_q == DONE);
    if (ready) begin
      rd = rot_q ? {res_q[2], res_q[1], res_q[0], res_q[3]}
                 : {res_q[3], res_q[2], res_q[1], res_q[0]};
    end else begin
      rd = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_aes_sub_multicycle.sv
module tb_aes_sub_multicycle;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic [2:0]  vld;
  logic [31:0] rs1, rs2;
  logic        enc, rot;
  logic [2:0]  rdy;
  logic [31:0] rdv [3];

  int n_total = 0;
  int n_bad   = 0;
  int pe      = 0;

  typedef struct { logic [31:0] rd; int pe; } exp_t;
  exp_t sb_q [3][$];

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) pe <= pe + 1;

  // DUT k uses 2^k sboxes.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    aes_sub_multicycle #(.SBOXES(1 << k)) u_dut (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .valid   (vld[k]),
      .rs1     (rs1),
      .rs2     (rs2),
      .enc     (enc),
      .rot     (rot),
      .ready   (rdy[k]),
      .rd      (rdv[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference tables from log/antilog (generator 3) plus a bitwise affine map.
  task automatic build_tables();
    logic [7:0] alog [256];
    logic [7:0] lg   [256];
    logic [7:0] a, iv, s;
    a = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = a;
      lg[a]   = 8'(i);
      a       = a ^ xt(a);
    end
    for (int x = 0; x < 256; x++) begin
      iv = (x == 0) ? 8'h00 : alog[(255 - int'(lg[x])) % 255];
      for (int b = 0; b < 8; b++) begin
        s[b] = iv[b] ^ iv[(b + 4) % 8] ^ iv[(b + 5) % 8] ^ iv[(b + 6) % 8]
             ^ iv[(b + 7) % 8] ^ ((8'h63 >> b) & 8'h01) != 8'h00;
      end
      fwd_t[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic e, input logic r);
    logic [7:0] s0, s1, s2, s3;
    s0 = e ? fwd_t[a[7:0]]   : inv_t[a[7:0]];
    s1 = e ? fwd_t[b[15:8]]  : inv_t[b[15:8]];
    s2 = e ? fwd_t[a[23:16]] : inv_t[a[23:16]];
    s3 = e ? fwd_t[b[31:24]] : inv_t[b[31:24]];
    model = r ? {s2, s1, s0, s3} : {s3, s2, s1, s0};
  endfunction

  // Scoreboard monitor: pop on ready, check value and cycle; rd must be 0 otherwise.
  always @(negedge g_clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rdy[k] === 1'b1) begin
        if (sb_q[k].size() == 0) begin
          check($sformatf("spurious_ready%0d", k), 32'd1, 32'd0);
        end else begin
          e = sb_q[k].pop_front();
          check($sformatf("rd%0d", k), rdv[k], e.rd);
          check($sformatf("ready_cycle%0d", k), pe, e.pe);
        end
      end else begin
        check($sformatf("rd_idle%0d", k), rdv[k], 32'h0000_0000);
      end
    end
  end

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic e, input logic r, input logic [31:0] exp_rd);
    exp_t x;
    bit got;
    @(negedge g_clk);
    rs1 = a; rs2 = b; enc = e; rot = r;
    vld[k] = 1'b1;
    x.rd = exp_rd;
    x.pe = pe + 1 + (4 >> k);
    sb_q[k].push_back(x);
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge g_clk);
      if (rdy[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    vld[k] = 1'b0;
    if (!got) check($sformatf("timeout%0d", k), 32'd0, 32'd1);
  endtask

  initial begin
    exp_t x;
    logic [31:0] ra, rb;
    logic re, rr;
    g_reset = 1'b1;
    vld = 3'b000;
    rs1 = 32'h0; rs2 = 32'h0; enc = 1'b0; rot = 1'b0;
    build_tables();
    repeat (3) @(negedge g_clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready%0d", k), {31'd0, rdy[k]}, 32'd0);
      check($sformatf("rst_rd%0d", k), rdv[k], 32'd0);
    end
    g_reset = 1'b0;

    run_op(0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h6363_6363);
    run_op(2, 32'h0053_0000, 32'h1000_0100, 1'b1, 1'b0, 32'hCAED_7C63);
    run_op(2, 32'h0053_0000, 32'h1000_0100, 1'b1, 1'b1, 32'hED7C_63CA);
    run_op(1, 32'h00ED_0063, 32'hCA00_7C00, 1'b0, 1'b0, 32'h1053_0100);

    // Abort: valid low during the second RUN cycle, no ready may follow.
    @(negedge g_clk);
    rs1 = 32'h1234_5678; rs2 = 32'h9abc_def0; enc = 1'b1; rot = 1'b0;
    vld[0] = 1'b1;
    repeat (2) @(negedge g_clk);
    vld[0] = 1'b0;
    repeat (8) @(negedge g_clk);
    run_op(0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h6363_6363);

    // Reset in the second cycle of an operation.
    @(negedge g_clk);
    rs1 = 32'hdead_beef; rs2 = 32'h0bad_f00d; enc = 1'b0; rot = 1'b1;
    vld[0] = 1'b1;
    repeat (2) @(negedge g_clk);
    g_reset = 1'b1;
    vld[0]  = 1'b0;
    @(negedge g_clk);
    g_reset = 1'b0;
    check("midrst_ready", {31'd0, rdy[0]}, 32'd0);
    check("midrst_rd", rdv[0], 32'd0);
    repeat (8) @(negedge g_clk);
    run_op(0, 32'h00ED_0063, 32'hCA00_7C00, 1'b0, 1'b0, 32'h1053_0100);

    // Valid held high 14 cycles: two completions, the third start is aborted.
    @(negedge g_clk);
    rs1 = 32'h0; rs2 = 32'h0; enc = 1'b1; rot = 1'b0;
    vld[0] = 1'b1;
    x.rd = 32'h6363_6363; x.pe = pe + 1 + 4;
    sb_q[0].push_back(x);
    x.pe = pe + 1 + 4 + 6;
    sb_q[0].push_back(x);
    repeat (14) @(negedge g_clk);
    vld[0] = 1'b0;
    repeat (10) @(negedge g_clk);
    check("b2b_pending", sb_q[0].size(), 32'd0);

    // Random operations against the table model.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom;
      re = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
      run_op(i % 3, ra, rb, re, rr, model(ra, rb, re, rr));
    end

    repeat (4) @(negedge g_clk);
    for (int k = 0; k < 3; k++) check($sformatf("pending%0d", k), sb_q[k].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
